rgb_led_sequencer: RTL and testbench
====================================

// Module: rgb_led_sequencer
// PURPOSE
//   Avalon-MM slave that sequences the board RGB LED through a 4-step colour pattern.
//   - Each step holds for a programmable number of clock cycles.
//   - Supports one-shot or looped runs, with a done flag and an optional level IRQ.
//   - Replaces per-colour PIO bit-banging from Nios software.
//   - Sits on the system interconnect beside the LED PIOs and drives led_r/led_g/led_b.
// PARAMETERS
//   PERIOD_W        24           width of the PERIOD register and the step counter
//   DEFAULT_PERIOD  24'd5000000  PERIOD value after reset (100 ms at 50 MHz)
//   NUM_STEPS       4            number of pattern slots; fixed at 4, step index is 2 bits
// PORTS
//   clk         in   1   system clock, single clock domain
//   reset_n     in   1   synchronous active-low reset, sampled on the rising edge of clk
//   address     in   3   Avalon word address
//   chipselect  in   1   Avalon slave select
//   write_n     in   1   Avalon write strobe, active low
//   writedata   in   32  Avalon write data
//   readdata    out  32  Avalon read data; combinational, read latency 0, no wait states
//   led_r       out  1   red LED drive, active high
//   led_g       out  1   green LED drive, active high
//   led_b       out  1   blue LED drive, active high
//   irq         out  1   level interrupt = STATUS.done & CTRL.irq_en
// BEHAVIOUR
//   Register map (write = chipselect & ~write_n; unused bits read 0):
//     0 CTRL    [0] enable  [1] loop  [2] irq_en
//     1 PERIOD  [PERIOD_W-1:0] step length in cycles; 0 is treated as 1
//     2 STATUS  [0] busy (RO)  [1] done (sticky, W1C)  [5:4] current step (RO)
//     3 reserved, reads 0, writes ignored
//     4-7 STEP0..STEP3  [2:0] = {b,g,r}
//   Reset values: all registers, the counter, the step index and the FSM go to 0.
//     - Exception: PERIOD resets to DEFAULT_PERIOD.
//     - Outputs after reset: led_* = 0, irq = 0.
//   FSM states: IDLE, RUN, DONE.
//     - IDLE: LEDs off.
//       - A CTRL write with enable=1 moves to RUN on the next edge, with step=0 and cnt=0.
//     - RUN: {led_b,led_g,led_r} = STEP[step][2:0], decoded from registered state.
//       - First pattern cycle is the cycle after the enabling write edge.
//       - cnt increments each cycle.
//       - When cnt >= max(PERIOD,1)-1: cnt <= 0 and the step ends.
//       - Using >= means a PERIOD shrunk mid-step ends the step on the next edge.
//     - End of step: if step < 3, step <= step+1.
//       - If step == 3 and loop=1: step <= 0 (wrap), stay in RUN.
//       - If step == 3 and loop=0: go to DONE, set done <= 1, CTRL.enable auto-clears.
//     - RUN, CTRL write with enable=0: go to IDLE next edge; LEDs 0 from the next cycle; done not set.
//     - RUN, CTRL write with enable=1: restart at step 0, cnt 0.
//     - DONE: LEDs 0. A CTRL write with enable=1 restarts exactly as from IDLE.
//   STEP writes take effect on the LEDs the cycle after the write. No shadowing.
//   STATUS.busy = (state == RUN).
//   done set and W1C in the same cycle: set wins.
//   Writes to CTRL.loop/irq_en are honoured immediately, including mid-run.
//   reset_n low in any state: IDLE on that edge, everything back to reset values.
// STRUCTURE
//   Shared package led_seq_pkg holds:
//     - register address localparams (ADDR_CTRL .. ADDR_STEP3)
//     - CTRL/STATUS bit positions
//     - FSM state encoding
//   Sub-module led_seq_timer(clk, reset_n, clear, period, tick):
//     - step counter with a max(period,1) compare
//     - one-cycle tick output
//   Top level holds the register file, read mux, FSM and step index.
// TESTING
//   1. Reset -> led_*=0, irq=0; PERIOD reads DEFAULT_PERIOD; other registers read 0.
//   2. STEP0..3 = 1,2,4,7; PERIOD=3; write CTRL=1 ->
//      - r, g, b, then rgb, each for exactly 3 cycles;
//      - then LEDs 0, STATUS reads 0x2, CTRL reads 0.
//   3. Same setup with CTRL=3 (loop) ->
//      - the pattern repeats past step 3, STATUS.busy stays 1;
//      - write CTRL=0 -> LEDs 0 on the next cycle, done=0.
//   4. PERIOD=0, CTRL=1 -> each step lasts 1 cycle and done is set after 4 cycles.
//      - Also: PERIOD shrunk from 10 to 2 at cnt=5 -> the step ends on the next edge.
//   5. CTRL=5, run to done -> irq=1.
//      - W1C STATUS=0x2 -> irq=0 on the next cycle.
//      - W1C issued on the done-setting cycle -> done stays 1.
//   6. reset_n low for 1 cycle mid-RUN at step 2 ->
//      - IDLE, LEDs 0, PERIOD back to its default, STATUS reads 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the RGB LED sequencer.
//   - Avalon register word addresses
//   - CTRL / STATUS bit positions
//   - FSM state encoding
package led_seq_pkg;

    localparam int NUM_STEPS = 4;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_RSVD   = 3'd3;
    localparam logic [2:0] ADDR_STEP0  = 3'd4;
    localparam logic [2:0] ADDR_STEP1  = 3'd5;
    localparam logic [2:0] ADDR_STEP2  = 3'd6;
    localparam logic [2:0] ADDR_STEP3  = 3'd7;

    // CTRL bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_STEP_LO = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/led_seq_timer.sv
// led_seq_timer: step-length counter.
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   clear    in  force the counter back to 0 (idle / restart)
//   period   in  step length in cycles; 0 behaves as 1
//   tick     out high in the last cycle of a step (cnt >= max(period,1)-1)
// The compare is >= so that shrinking period below the current count ends
// the step on the very next edge instead of wrapping the counter.
module led_seq_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic [PERIOD_W-1:0] last;

    assign last  = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick  = (cnt_q >= last);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + PERIOD_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: Avalon-MM slave stepping the RGB LED through 4 colours.
//   clk, reset_n                 clock, synchronous active-low reset
//   address/chipselect/write_n/  Avalon-MM slave, 0-latency combinational read
//   writedata/readdata
//   led_r/led_g/led_b            LED drive, active high
//   irq                          level interrupt = STATUS.done & CTRL.irq_en
// Register map: 0 CTRL{irq_en,loop,enable}, 1 PERIOD, 2 STATUS{step,-,done,busy},
// 3 reserved, 4..7 STEP0..3 {b,g,r}.
module rgb_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int                  PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        irq
);

    state_e              state_q;
    logic [1:0]          step_q;
    logic                en_q, loop_q, irq_en_q, done_q, done_d;
    logic [PERIOD_W-1:0] period_q;
    logic [2:0]          pat_q [NUM_STEPS];

    logic wr, wr_ctrl, wr_period, wr_step, w1c_done;
    logic tick, run, step_end, last_step, set_done;
    logic unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_period = wr && (address == ADDR_PERIOD);
    assign wr_step   = wr && address[2];
    assign w1c_done  = wr && (address == ADDR_STATUS) && writedata[ST_DONE];
    assign unused_wd = ^writedata[31:PERIOD_W];

    assign run       = (state_q == S_RUN);
    assign step_end  = run && tick;
    assign last_step = (step_q == 2'd3);
    // A CTRL write in the same cycle overrides the natural end of the run.
    assign set_done  = step_end && last_step && !loop_q && !wr_ctrl;
    // Set beats W1C when both land in the same cycle.
    assign done_d    = set_done | (done_q & ~w1c_done);

    // Counter is held at 0 outside RUN and restarted by any CTRL write.
    led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run || wr_ctrl),
        .period  (period_q),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            step_q   <= 2'd0;
            en_q     <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            period_q <= DEFAULT_PERIOD;
            for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= 3'b000;
        end else begin
            done_q <= done_d;
            if (wr_period) period_q <= writedata[PERIOD_W-1:0];
            if (wr_step)   pat_q[address[1:0]] <= writedata[2:0];

            if (wr_ctrl) begin
                en_q     <= writedata[CTRL_EN];
                loop_q   <= writedata[CTRL_LOOP];
                irq_en_q <= writedata[CTRL_IRQ_EN];
                state_q  <= writedata[CTRL_EN] ? S_RUN : S_IDLE;
                step_q   <= 2'd0;
            end else if (step_end) begin
                if (!last_step) begin
                    step_q <= step_q + 2'd1;
                end else if (loop_q) begin
                    step_q <= 2'd0;
                end else begin
                    state_q <= S_DONE;
                    step_q  <= 2'd0;
                    en_q    <= 1'b0;
                end
            end
        end
    end

    assign {led_b, led_g, led_r} = run ? pat_q[step_q] : 3'b000;
    assign irq = done_q & irq_en_q;

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN]     = en_q;
                readdata[CTRL_LOOP]   = loop_q;
                readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_STATUS: begin
                readdata[ST_BUSY]          = run;
                readdata[ST_DONE]          = done_q;
                readdata[ST_STEP_LO +: 2]  = step_q;
            end
            ADDR_STEP0, ADDR_STEP1, ADDR_STEP2, ADDR_STEP3:
                readdata = {29'd0, pat_q[address[1:0]]};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
module tb_rgb_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        led_r, led_g, led_b, irq;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int DEF_PERIOD = 5000000;

    always #5 clk = ~clk;

    rgb_led_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_r      (led_r),
        .led_g      (led_g),
        .led_b      (led_b),
        .irq        (irq)
    );

    // Reference model: a run is "step k, age cycles into it"; a step lasts
    // max(PERIOD,1) cycles.
    bit       m_run, m_en, m_loop, m_irqen, m_done;
    int       m_step, m_age, m_period;
    bit [2:0] m_pat [4];

    function automatic void m_reset();
        m_run = 0; m_en = 0; m_loop = 0; m_irqen = 0; m_done = 0;
        m_step = 0; m_age = 0; m_period = DEF_PERIOD;
        for (int i = 0; i < 4; i++) m_pat[i] = 3'b000;
    endfunction

    function automatic void m_edge(input bit we, input bit [2:0] a, input bit [31:0] d);
        int  lim;
        bit  setdone, w1c;
        lim = (m_period == 0) ? 1 : m_period;
        setdone = 0; w1c = 0;
        if (m_run) begin
            if (m_age + 1 >= lim) begin
                m_age = 0;
                if (m_step < 3)  m_step++;
                else if (m_loop) m_step = 0;
                else begin m_run = 0; m_step = 0; m_en = 0; setdone = 1; end
            end else m_age++;
        end
        if (we) begin
            case (a)
                3'd0: begin
                    m_en = d[0]; m_loop = d[1]; m_irqen = d[2];
                    m_run = d[0]; m_step = 0; m_age = 0; setdone = 0;
                end
                3'd1: m_period = int'(d[23:0]);
                3'd2: w1c = d[1];
                3'd4, 3'd5, 3'd6, 3'd7: m_pat[a - 3'd4] = d[2:0];
                default: ;
            endcase
        end
        m_done = setdone | (m_done & ~w1c);
    endfunction

    function automatic bit [2:0] m_led();
        return m_run ? m_pat[m_step] : 3'b000;
    endfunction

    function automatic bit [31:0] m_read(input bit [2:0] a);
        case (a)
            3'd0: return {29'd0, m_irqen, m_loop, m_en};
            3'd1: return 32'(m_period);
            3'd2: return 32'((m_step << 4) | (int'(m_done) << 1) | int'(m_run));
            3'd4, 3'd5, 3'd6, 3'd7: return {29'd0, m_pat[a - 3'd4]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] led_now();
        return {29'd0, led_b, led_g, led_r};
    endfunction

    // One clock: optional write, model update at the edge, outputs checked after.
    task automatic tick(input bit we, input bit [2:0] a, input bit [31:0] d);
        chipselect = we; write_n = ~we; address = a; writedata = d;
        @(posedge clk);
        m_edge(we, a, d);
        #1;
        chipselect = 0; write_n = 1;
        chk("led", led_now(), {29'd0, m_led()});
        chk("irq", {31'd0, irq}, {31'd0, m_done & m_irqen});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 3'd0, 32'd0);
    endtask

    task automatic rd(input string nm, input bit [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 1; write_n = 1;
        #1;
        chk(nm, readdata, exp);
        chipselect = 0;
    endtask

    task automatic do_reset();
        chipselect = 0; write_n = 1; reset_n = 0;
        @(posedge clk);
        m_reset();
        #1;
        reset_n = 1;
        chk("rst_led", led_now(), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  addr;
        bit [31:0] data;
        bit [2:0]  exp_bgr;
    } vec_t;

    typedef struct {
        bit [2:0]  addr;
        bit [31:0] exp;
    } rd_t;

    vec_t v2 [19];
    rd_t  rv [8];

    initial begin
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
        m_reset();

        // 1. reset state
        do_reset();
        do_reset();
        rv[0] = '{3'd0, 32'd0};
        rv[1] = '{3'd1, 32'(DEF_PERIOD)};
        rv[2] = '{3'd2, 32'd0};
        rv[3] = '{3'd3, 32'd0};
        rv[4] = '{3'd4, 32'd0};
        rv[5] = '{3'd5, 32'd0};
        rv[6] = '{3'd6, 32'd0};
        rv[7] = '{3'd7, 32'd0};
        for (int i = 0; i < 8; i++) rd("rst_reg", rv[i].addr, rv[i].exp);

        // 2. one-shot pattern r, g, b, rgb for 3 cycles each
        v2[0] = '{1, 3'd4, 32'd1, 3'd0};
        v2[1] = '{1, 3'd5, 32'd2, 3'd0};
        v2[2] = '{1, 3'd6, 32'd4, 3'd0};
        v2[3] = '{1, 3'd7, 32'd7, 3'd0};
        v2[4] = '{1, 3'd1, 32'd3, 3'd0};
        v2[5] = '{1, 3'd0, 32'd1, 3'd1};
        v2[6]  = '{0, 3'd0, 32'd0, 3'd1};
        v2[7]  = '{0, 3'd0, 32'd0, 3'd1};
        v2[8]  = '{0, 3'd0, 32'd0, 3'd2};
        v2[9]  = '{0, 3'd0, 32'd0, 3'd2};
        v2[10] = '{0, 3'd0, 32'd0, 3'd2};
        v2[11] = '{0, 3'd0, 32'd0, 3'd4};
        v2[12] = '{0, 3'd0, 32'd0, 3'd4};
        v2[13] = '{0, 3'd0, 32'd0, 3'd4};
        v2[14] = '{0, 3'd0, 32'd0, 3'd7};
        v2[15] = '{0, 3'd0, 32'd0, 3'd7};
        v2[16] = '{0, 3'd0, 32'd0, 3'd7};
        v2[17] = '{0, 3'd0, 32'd0, 3'd0};
        v2[18] = '{0, 3'd0, 32'd0, 3'd0};
        for (int i = 0; i < 19; i++) begin
            tick(v2[i].we, v2[i].addr, v2[i].data);
            chk("t2_seq", led_now(), {29'd0, v2[i].exp_bgr});
        end
        rd("t2_status", 3'd2, 32'h2);
        rd("t2_ctrl", 3'd0, 32'h0);

        // 3. looped run, then stop
        tick(1, 3'd2, 32'h2);
        tick(1, 3'd0, 32'h3);
        idle(12);
        chk("t3_wrap", led_now(), 32'd1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            rd("t3_status", 3'd2, m_read(3'd2));
            chk("t3_busy", {31'd0, readdata[0]}, 32'd1);
        end
        tick(1, 3'd0, 32'h0);
        chk("t3_stop_led", led_now(), 32'd0);
        rd("t3_stop_status", 3'd2, 32'h0);

        // 4. PERIOD=0 behaves as 1
        tick(1, 3'd1, 32'd0);
        tick(1, 3'd0, 32'h1);
        chk("t4_s0", led_now(), 32'd1);
        idle(1); chk("t4_s1", led_now(), 32'd2);
        idle(1); chk("t4_s2", led_now(), 32'd4);
        idle(1); chk("t4_s3", led_now(), 32'd7);
        idle(1); chk("t4_off", led_now(), 32'd0);
        rd("t4_status", 3'd2, 32'h2);
        tick(1, 3'd2, 32'h2);
        //    PERIOD shrunk from 10 to 2 at cnt=5
        tick(1, 3'd1, 32'd10);
        tick(1, 3'd0, 32'h1);
        idle(5);
        tick(1, 3'd1, 32'd2);
        chk("t4_shrink_hold", led_now(), 32'd1);
        idle(1);
        chk("t4_shrink_end", led_now(), 32'd2);
        tick(1, 3'd0, 32'h0);

        // 5. irq, W1C, and set-wins-over-clear
        tick(1, 3'd1, 32'd1);
        tick(1, 3'd0, 32'h5);
        idle(3);
        chk("t5_last", led_now(), 32'd7);
        idle(1);
        chk("t5_irq_set", {31'd0, irq}, 32'd1);
        rd("t5_ctrl", 3'd0, 32'h4);
        tick(1, 3'd2, 32'h2);
        chk("t5_irq_clr", {31'd0, irq}, 32'd0);
        tick(1, 3'd0, 32'h5);
        idle(3);
        tick(1, 3'd2, 32'h2);
        chk("t5_set_wins", {31'd0, irq}, 32'd1);
        rd("t5_status", 3'd2, 32'h2);
        tick(1, 3'd2, 32'h2);

        // 6. reset mid-run at step 2
        tick(1, 3'd1, 32'd3);
        tick(1, 3'd0, 32'h1);
        idle(6);
        chk("t6_step2", led_now(), 32'd4);
        do_reset();
        rd("t6_period", 3'd1, 32'(DEF_PERIOD));
        rd("t6_status", 3'd2, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)       tick(1, 3'd0, 32'($urandom_range(0, 7)));
            else if (r < 14) tick(1, 3'd1, 32'($urandom_range(0, 4)));
            else if (r < 22) tick(1, 3'd2, $urandom);
            else if (r < 24) tick(1, 3'd3, $urandom);
            else if (r < 36) tick(1, 3'($urandom_range(4, 7)), $urandom);
            else if (r < 37) do_reset();
            else             tick(0, 3'd0, 32'd0);
            if (i % 7 == 0) begin
                bit [2:0] a;
                a = 3'($urandom_range(0, 7));
                rd("rand_read", a, m_read(a));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
